reg_slice: RTL and testbench

- Parametrised valid/ready pipeline register. It is the handshake-aware successor to the plain dff/dffr/dfflr primitives.
- Chains STAGES identical stages. Each stage works in one of four modes: bypass, forward-registered, full skid buffer, or half-throughput.
- Used to break timing paths between producer and consumer blocks on buses and streams.
- Adds a synchronous flush and an occupancy count.

---
 rtl/reg_slice_pkg.sv | 32 +++
 rtl/reg_slice_stage.sv | 130 +++++++++++++
 rtl/reg_slice.sv | 87 ++++++++
 tb/tb_reg_slice.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_slice_pkg.sv
// reg_slice_pkg: shared types for the valid/ready pipeline register.
// Slice mode and skid-buffer state encodings plus count sizing helper.
package reg_slice_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_FWD    = 2'd1,
    MODE_FULL   = 2'd2,
    MODE_HALF   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // Minimum bits needed to hold the largest possible occupancy.
  function automatic int cnt_width(
    input int    stages,
    input mode_e mode
  );
    int cap;
    case (mode)
      MODE_BYPASS: cap = 0;
      MODE_FULL:   cap = 2 * stages;
      default:     cap = stages;
    endcase
    return (cap < 1) ? 1 : $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/reg_slice_stage.sv
// reg_slice_stage: one valid/ready register stage.
// Forward-registered, skid buffer, half-throughput or pass-through.
module reg_slice_stage
  import reg_slice_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter mode_e                 MODE       = MODE_FULL,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_dat
);

  if (MODE == MODE_FULL) begin : g_full
    state_e                r_state;
    state_e                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main;
    logic [DATA_WIDTH-1:0] r_skid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_ld_main;
    logic                  w_ld_skid;
    logic                  w_skid2main;

    assign o_ready = (r_state != TWO);
    assign o_valid = (r_state != EMPTY);
    assign o_dat   = r_main;
    assign w_push  = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_comb begin
      w_state_nxt = r_state;
      w_ld_main   = 1'b0;
      w_ld_skid   = 1'b0;
      w_skid2main = 1'b0;
      unique case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_state_nxt = ONE;
            w_ld_main   = 1'b1;
          end
        end
        ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = TWO;
            w_ld_skid   = 1'b1;
          end else if (w_pop && !w_push) begin
            w_state_nxt = EMPTY;
          end else if (w_push && w_pop) begin
            w_ld_main = 1'b1;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt = ONE;
            w_skid2main = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
      if (flush_i) w_state_nxt = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= EMPTY;
      else          r_state <= w_state_nxt;
    end

    // Data registers only follow accepts; flush leaves them alone.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_main <= RESET_VAL;
        r_skid <= RESET_VAL;
      end else begin
        if (w_ld_main)        r_main <= i_dat;
        else if (w_skid2main) r_main <= r_skid;
        if (w_ld_skid)        r_skid <= i_dat;
      end
    end
  end else if (MODE == MODE_FWD) begin : g_fwd
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_dat;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_dat   = r_dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     r_valid <= 1'b0;
      else if (flush_i) r_valid <= 1'b0;
      else if (o_ready) r_valid <= i_valid;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                r_dat <= RESET_VAL;
      else if (i_valid && o_ready) r_dat <= i_dat;
    end
  end else if (MODE == MODE_HALF) begin : g_half
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_dat;

    assign o_ready = ~r_valid;
    assign o_valid = r_valid;
    assign o_dat   = r_dat;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                 r_valid <= 1'b0;
      else if (flush_i)             r_valid <= 1'b0;
      else if (i_valid && !r_valid) r_valid <= 1'b1;
      else if (i_ready)             r_valid <= 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)                 r_dat <= RESET_VAL;
      else if (i_valid && !r_valid) r_dat <= i_dat;
    end
  end else begin : g_bypass
    assign o_ready = i_ready;
    assign o_valid = i_valid;
    assign o_dat   = i_dat;
  end

endmodule

// File: rtl/reg_slice.sv
// reg_slice: chain of valid/ready register stages with flush and
// occupancy count, used to cut timing paths on streams and buses.
module reg_slice
  import reg_slice_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    STAGES     = 1,
  parameter mode_e                 MODE       = MODE_FULL,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter int                    CNT_W      = $clog2(2*STAGES+1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [DATA_WIDTH-1:0] src_dat_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [DATA_WIDTH-1:0] dst_dat_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  busy_o
);

  if (STAGES < 1 || DATA_WIDTH < 1) begin : g_bad_param
    $fatal(1, "reg_slice: STAGES and DATA_WIDTH must be >= 1");
  end

  if (CNT_W < cnt_width(STAGES, MODE)) begin : g_bad_cnt
    $fatal(1, "reg_slice: CNT_W too narrow for occupancy");
  end

  if (MODE == MODE_BYPASS) begin : g_bypass
    assign dst_valid_o = src_valid_i;
    assign dst_dat_o   = src_dat_i;
    assign src_ready_o = dst_ready_i;
    assign count_o     = '0;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    logic                  w_valid [STAGES+1];
    logic                  w_ready [STAGES+1];
    logic [DATA_WIDTH-1:0] w_dat   [STAGES+1];
    logic [CNT_W-1:0]      r_count;
    logic                  w_src_xfer;
    logic                  w_dst_xfer;

    assign w_valid[0]      = src_valid_i;
    assign w_dat[0]        = src_dat_i;
    assign src_ready_o     = w_ready[0];
    assign w_ready[STAGES] = dst_ready_i;
    assign dst_valid_o     = w_valid[STAGES];
    assign dst_dat_o       = w_dat[STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
      reg_slice_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .MODE       (MODE),
        .RESET_VAL  (RESET_VAL)
      ) u_stage (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .i_valid (w_valid[s]),
        .o_ready (w_ready[s]),
        .i_dat   (w_dat[s]),
        .o_valid (w_valid[s+1]),
        .i_ready (w_ready[s+1]),
        .o_dat   (w_dat[s+1])
      );
    end

    assign w_src_xfer = src_valid_i & src_ready_o;
    assign w_dst_xfer = dst_valid_o & dst_ready_i;

    // Items caught in a flush are gone, so occupancy restarts at zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)     r_count <= '0;
      else if (flush_i) r_count <= '0;
      else              r_count <= r_count + CNT_W'(w_src_xfer)
                                           - CNT_W'(w_dst_xfer);
    end

    assign count_o = r_count;
    assign busy_o  = (r_count != '0);
  end

endmodule

// File: tb/tb_reg_slice.sv
// tb_reg_slice: four slice configurations run side by side, each
// checked by a queue scoreboard plus directed scenario checks.
module tb_reg_slice;
  import reg_slice_pkg::*;

  localparam int        N   = 4;
  localparam logic [7:0] RST = 8'hA5;

  function automatic mode_e mode_of(input int k);
    case (k)
      2:       return MODE_HALF;
      3:       return MODE_FWD;
      default: return MODE_FULL;
    endcase
  endfunction

  function automatic int stg_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [N-1:0] src_valid, src_ready, dst_valid, dst_ready;
  logic [N-1:0] flush, busy;
  logic [7:0] src_dat [N];
  logic [7:0] dst_dat [N];
  logic [3:0] count [N];

  int n_chk = 0;
  int n_err = 0;
  int ncyc = 0;
  logic [7:0] sbq [N][$];
  int first_src [N];
  int first_dv [N];
  int first_dx [N];
  int last_dx [N];
  int n_dst [N];
  logic [N-1:0] prev_hold = '0;
  logic [7:0] prev_dat [N];

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    localparam int S = stg_of(k);
    logic [$clog2(2*S+1)-1:0] cnt;
    reg_slice #(
      .DATA_WIDTH (8),
      .STAGES     (S),
      .MODE       (mode_of(k)),
      .RESET_VAL  (RST)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .flush_i     (flush[k]),
      .src_valid_i (src_valid[k]),
      .src_ready_o (src_ready[k]),
      .src_dat_i   (src_dat[k]),
      .dst_valid_o (dst_valid[k]),
      .dst_ready_i (dst_ready[k]),
      .dst_dat_o   (dst_dat[k]),
      .count_o     (cnt),
      .busy_o      (busy[k])
    );
    assign count[k] = 4'(cnt);
  end

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Scoreboard: the model is just the ordered list of held items.
  always @(negedge clk) begin
    ncyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        sbq[k].delete();
        prev_hold[k] = 1'b0;
      end else begin
        chk($sformatf("count%0d", k), count[k], sbq[k].size());
        chk($sformatf("busy%0d", k), busy[k], sbq[k].size() != 0);
        if (prev_hold[k]) begin
          chk($sformatf("hold_v%0d", k), dst_valid[k], 1);
          chk($sformatf("hold_d%0d", k), dst_dat[k], prev_dat[k]);
        end
        if (dst_valid[k] && first_dv[k] < 0) first_dv[k] = ncyc;
        if (dst_valid[k] && dst_ready[k]) begin
          if (sbq[k].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL extra_out%0d: got %0h want none", k, dst_dat[k]);
          end else begin
            chk($sformatf("dat%0d", k), dst_dat[k], sbq[k].pop_front());
          end
          n_dst[k]++;
          if (first_dx[k] < 0) first_dx[k] = ncyc;
          last_dx[k] = ncyc;
        end
        if (src_valid[k] && src_ready[k]) begin
          if (first_src[k] < 0) first_src[k] = ncyc;
          if (!flush[k]) sbq[k].push_back(src_dat[k]);
        end
        if (flush[k]) sbq[k].delete();
        prev_hold[k] = dst_valid[k] && !dst_ready[k] && !flush[k];
        prev_dat[k] = dst_dat[k];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark(input int k);
    first_src[k] = -1;
    first_dv[k]  = -1;
    first_dx[k]  = -1;
    last_dx[k]   = -1;
    n_dst[k]     = 0;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    int n;
    n = 0;
    src_valid[k] = 1'b1;
    src_dat[k]   = d;
    #1;
    while (!src_ready[k] && n < 100) begin
      step();
      #1;
      n++;
    end
    if (!src_ready[k]) begin
      n_chk++;
      n_err++;
      $display("FAIL push_timeout%0d: got ready 0 want 1", k);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    src_valid = '0;
    dst_ready = '0;
    flush     = '0;
    for (int k = 0; k < N; k++) begin
      src_dat[k] = '0;
      mark(k);
    end
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_valid", dst_valid[k], 0);
      chk("rst_dat", dst_dat[k], RST);
      chk("rst_count", count[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_ready", src_ready[k], 1);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // Back-to-back stream through two skid stages
    mark(0);
    dst_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) push(0, 8'(i));
    src_valid[0] = 1'b0;
    for (int i = 0; i < 30 && n_dst[0] < 16; i++) step();
    chk("A_n_out", n_dst[0], 16);
    chk("A_latency", first_dv[0] - first_src[0], 2);
    chk("A_consec", last_dx[0] - first_dx[0], 15);

    // Skid buffer fills to two and backpressures the third item
    mark(1);
    dst_ready[1] = 1'b0;
    push(1, 8'h11);
    push(1, 8'h22);
    src_valid[1] = 1'b1;
    src_dat[1]   = 8'h33;
    repeat (3) step();
    chk("B_count", count[1], 2);
    chk("B_ready", src_ready[1], 0);
    chk("B_valid", dst_valid[1], 1);
    chk("B_head", dst_dat[1], 8'h11);
    dst_ready[1] = 1'b1;
    push(1, 8'h33);
    src_valid[1] = 1'b0;
    for (int i = 0; i < 20 && count[1] != 0; i++) step();
    chk("B_drain", count[1], 0);
    chk("B_n_out", n_dst[1], 3);

    // Half-throughput stage alternates ready
    mark(2);
    dst_ready[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(2, 8'hC0 + 8'(i));
      chk("C_ready_low", src_ready[2], 0);
    end
    src_valid[2] = 1'b0;
    for (int i = 0; i < 20 && n_dst[2] < 8; i++) step();
    chk("C_n_out", n_dst[2], 8);
    chk("C_span", last_dx[2] - first_src[2], 15);

    // Forward stage: ready follows dst_ready in the same cycle
    mark(3);
    dst_ready[3] = 1'b0;
    push(3, 8'h5A);
    src_valid[3] = 1'b1;
    src_dat[3]   = 8'h6B;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("D_ready_low", src_ready[3], 0);
      chk("D_dat", dst_dat[3], 8'h5A);
      step();
    end
    dst_ready[3] = 1'b1;
    #1;
    chk("D_ready_comb", src_ready[3], 1);
    step();
    src_valid[3] = 1'b0;
    repeat (3) step();
    chk("D_n_out", n_dst[3], 2);

    // Flush with an item accepted in the same cycle
    mark(0);
    dst_ready[0] = 1'b0;
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    src_valid[0] = 1'b0;
    step();
    chk("E_count3", count[0], 3);
    flush[0]     = 1'b1;
    src_valid[0] = 1'b1;
    src_dat[0]   = 8'h55;
    step();
    flush[0]     = 1'b0;
    src_valid[0] = 1'b0;
    chk("E_valid", dst_valid[0], 0);
    chk("E_count", count[0], 0);
    chk("E_busy", busy[0], 0);
    dst_ready[0] = 1'b1;
    repeat (4) step();
    chk("E_no_out", n_dst[0], 0);

    // Random traffic on every configuration
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++) begin
        src_valid[k] = ($urandom_range(9) < 7);
        src_dat[k]   = 8'($urandom);
        dst_ready[k] = ($urandom_range(9) < 6);
        flush[k]     = ($urandom_range(49) == 0);
      end
      step();
    end
    src_valid = '0;
    flush     = '0;
    dst_ready = '1;
    repeat (10) step();
    for (int k = 0; k < N; k++) chk("R_drain", count[k], 0);

    // Asynchronous reset with items in flight
    dst_ready[0] = 1'b0;
    push(0, 8'hE1);
    push(0, 8'hE2);
    src_valid[0] = 1'b0;
    step();
    chk("X_count2", count[0], 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("X_valid", dst_valid[0], 0);
    chk("X_dat", dst_dat[0], RST);
    chk("X_count", count[0], 0);
    chk("X_busy", busy[0], 0);
    chk("X_ready", src_ready[0], 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("X_after", count[0], 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
